// File: rtl/interrupt_capture_ctrl.sv
// Interrupt capture front end: synchronises and edge-detects interrupt lines, latches
// pending/overflow, and posts the highest-priority cause/vector into the register file.
module interrupt_capture_ctrl #(
  parameter int                   word_size        = 32,
  parameter int                   reg_address_size = 5,
  parameter int                   NUM_SOURCES      = 8,
  parameter int                   CAUSE_ADDR       = 0,
  parameter int                   VEC_ADDR         = 1,
  parameter logic [word_size-1:0] VECTOR_BASE      = 'h100,
  parameter logic [word_size-1:0] VECTOR_STRIDE    = 'h10
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_SOURCES-1:0]      irq_in,
  input  logic [NUM_SOURCES-1:0]      irq_mask,
  input  logic                        cpu_ack,
  output logic [word_size-1:0]        ir_data_in,
  output logic [reg_address_size-1:0] ir_address,
  output logic                        store,
  output logic                        load,
  output logic                        cpu_irq,
  output logic [3:0]                  active_id,
  output logic                        busy
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    STORE_CAUSE = 3'd1,
    STORE_VEC   = 3'd2,
    NOTIFY      = 3'd3,
    RELEASE     = 3'd4,
    CLEAR_CAUSE = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             active_id_q, active_id_d;
  logic [NUM_SOURCES-1:0] sync1_q, sync1_d;
  logic [NUM_SOURCES-1:0] sync2_q, sync2_d;
  logic [NUM_SOURCES-1:0] dly_q, dly_d;
  logic [NUM_SOURCES-1:0] pending_q, pending_d;
  logic [NUM_SOURCES-1:0] overflow_q, overflow_d;

  logic [NUM_SOURCES-1:0] rise;
  logic [NUM_SOURCES-1:0] clr;
  logic [NUM_SOURCES-1:0] sel;
  logic [3:0]             sel_id;
  logic                   ack_take;
  logic                   ovf_sel;
  logic [word_size-1:0]   cause_word;
  logic [word_size-1:0]   vec_word;

  // Capture: two sync flops, a third for edge detect; set beats clear on one source
  always_comb begin
    sync1_d  = irq_in;
    sync2_d  = sync1_q;
    dly_d    = sync2_q;
    rise     = sync2_q & ~dly_q;
    ack_take = (state_q == NOTIFY) && cpu_ack;
    clr      = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (ack_take && (active_id_q == 4'(i))) clr[i] = 1'b1;
    end
    pending_d  = (pending_q & ~clr) | rise;
    overflow_d = (overflow_q & ~clr) | (rise & pending_q & ~clr);
  end

  // Lowest index wins
  always_comb begin
    sel    = pending_q & irq_mask;
    sel_id = 4'd0;
    for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
      if (sel[i]) sel_id = 4'(i);
    end
  end

  always_comb begin
    ovf_sel = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (active_id_q == 4'(i)) ovf_sel = overflow_q[i];
    end
    cause_word                = '0;
    cause_word[word_size-1]   = 1'b1;
    cause_word[8]             = ovf_sel;
    cause_word[3:0]           = active_id_q;
    vec_word = VECTOR_BASE + word_size'(active_id_q) * VECTOR_STRIDE;
  end

  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    case (state_q)
      IDLE: begin
        if (|sel) begin
          active_id_d = sel_id;
          state_d     = STORE_CAUSE;
        end
      end
      STORE_CAUSE: state_d = STORE_VEC;
      STORE_VEC:   state_d = NOTIFY;
      NOTIFY:      if (cpu_ack) state_d = RELEASE;
      RELEASE:     if (!cpu_ack) state_d = CLEAR_CAUSE;
      CLEAR_CAUSE: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Moore output decode from registered state
  always_comb begin
    store      = 1'b0;
    ir_address = '0;
    ir_data_in = '0;
    cpu_irq    = 1'b0;
    load       = 1'b0;
    busy       = (state_q != IDLE);
    active_id  = (state_q == IDLE) ? 4'd0 : active_id_q;
    case (state_q)
      STORE_CAUSE: begin
        store      = 1'b1;
        ir_address = reg_address_size'(CAUSE_ADDR);
        ir_data_in = cause_word;
      end
      STORE_VEC: begin
        store      = 1'b1;
        ir_address = reg_address_size'(VEC_ADDR);
        ir_data_in = vec_word;
      end
      NOTIFY:      cpu_irq = 1'b1;
      CLEAR_CAUSE: begin
        store      = 1'b1;
        ir_address = reg_address_size'(CAUSE_ADDR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      active_id_q <= 4'd0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      dly_q       <= '0;
      pending_q   <= '0;
      overflow_q  <= '0;
    end else begin
      state_q     <= state_d;
      active_id_q <= active_id_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      dly_q       <= dly_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
